// File: rtl/s2_hyp_cordic.sv
// Hyperbolic CORDIC second stage: iterative rotation-mode core producing cosh/sinh
// from pre-scaled seeds and a residual angle, one micro-iteration per clock.
package hyperCord_pkg;
    localparam int I_INT_WIDTH  = 3;
    localparam int I_FRA_WIDTH  = 16;
    localparam int I_SIGN_WIDTH = 1;
    localparam int IDWIDTH      = I_SIGN_WIDTH + I_INT_WIDTH + I_FRA_WIDTH;
endpackage

module s2_hyp_cordic
    import hyperCord_pkg::*;
#(
    parameter int INT_WIDTH  = I_INT_WIDTH,
    parameter int FRA_WIDTH  = I_FRA_WIDTH,
    parameter int SIGN_WIDTH = I_SIGN_WIDTH,
    parameter int DWIDTH     = SIGN_WIDTH + INT_WIDTH + FRA_WIDTH
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              iReady,
    input  logic [DWIDTH-1:0] iX,
    input  logic [DWIDTH-1:0] iY,
    input  logic [DWIDTH-1:0] iZ,
    output logic              oValid,
    input  logic              oReady,
    output logic [DWIDTH-1:0] coshOut,
    output logic [DWIDTH-1:0] sinhOut
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 18 micro-iterations: shifts 1..16 with 4 and 13 executed twice
    localparam logic [4:0] LAST_ITER = 5'd17;

    // atanh(2^-i) as a truncated Taylor series at 48 fractional bits, rounded to FRA_WIDTH
    function automatic logic signed [DWIDTH-1:0] atanh_q(input int i);
        longint unsigned acc;
        longint unsigned rnd;
        int              sh;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            sh = i * (2 * k + 1);
            if (sh <= 48) begin
                acc += (64'd1 << (48 - sh)) / 64'(2 * k + 1);
            end
        end
        rnd = (acc + (64'd1 << (47 - FRA_WIDTH))) >> (48 - FRA_WIDTH);
        return DWIDTH'(rnd);
    endfunction

    logic signed [DWIDTH-1:0] atanh_tab [32];

    for (genvar g = 0; g < 32; g++) begin : g_atanh
        if (g >= 1 && g <= 16) begin : g_ent
            assign atanh_tab[g] = atanh_q(g);
        end else begin : g_nil
            assign atanh_tab[g] = '0;
        end
    end

    logic [1:0]               state_q, state_d;
    logic signed [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [DWIDTH-1:0] cosh_q, cosh_d, sinh_q, sinh_d;
    logic [4:0]               idx_q, idx_d, cnt_q, cnt_d;
    logic                     rep_q, rep_d;
    logic                     ovalid_q, ovalid_d;

    logic signed [DWIDTH-1:0] x_sh, y_sh, ang;
    logic signed [DWIDTH-1:0] x_nxt, y_nxt, z_nxt;

    assign iReady  = (state_q == S_IDLE);
    assign oValid  = ovalid_q;
    assign coshOut = cosh_q;
    assign sinhOut = sinh_q;

    // One rotation step; every update uses pre-update x/y/z and wraps modulo 2^DWIDTH
    always_comb begin
        x_sh = x_q >>> idx_q;
        y_sh = y_q >>> idx_q;
        ang  = atanh_tab[idx_q];
        if (!z_q[DWIDTH-1]) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - ang;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + ang;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        cosh_d   = cosh_q;
        sinh_d   = sinh_q;
        ovalid_d = ovalid_q;
        case (state_q)
            S_IDLE: begin
                if (iValid && iReady) begin
                    state_d = S_RUN;
                    x_d     = $signed(iX);
                    y_d     = $signed(iY);
                    z_d     = $signed(iZ);
                    idx_d   = 5'd1;
                    rep_d   = 1'b0;
                    cnt_d   = 5'd0;
                end
            end
            S_RUN: begin
                x_d   = x_nxt;
                y_d   = y_nxt;
                z_d   = z_nxt;
                cnt_d = cnt_q + 5'd1;
                if ((idx_q == 5'd4 || idx_q == 5'd13) && !rep_q) begin
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    idx_d = idx_q + 5'd1;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d  = S_DONE;
                    cosh_d   = x_nxt;
                    sinh_d   = y_nxt;
                    ovalid_d = 1'b1;
                    cnt_d    = 5'd0;
                end
            end
            S_DONE: begin
                if (oReady) begin
                    state_d  = S_IDLE;
                    ovalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            idx_q    <= '0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
            cosh_q   <= '0;
            sinh_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            cnt_q    <= cnt_d;
            cosh_q   <= cosh_d;
            sinh_q   <= sinh_d;
            ovalid_q <= ovalid_d;
        end
    end

endmodule

// File: tb/tb_s2_hyp_cordic.sv
// Scoreboard bench for s2_hyp_cordic: the driver queues expected results at accept,
// an independent monitor pops and checks them when the block presents a result.
module tb_s2_hyp_cordic;

    localparam int DW = 20;

    logic          iClk = 1'b0;
    logic          iRst, iValid, iReady, oValid, oReady;
    logic [DW-1:0] iX, iY, iZ, coshOut, sinhOut;

    typedef struct {
        int c;
        int s;
        int tol;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int vx[3] = '{79134, 79134, 79134};
    int vz[3] = '{0, 32768, -32768};
    int vc[3] = '{65536, 73900, 73900};
    int vs[3] = '{0, 34151, -34151};
    int vt[3] = '{8, 16, 16};

    s2_hyp_cordic dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .iReady (iReady),
        .iX     (iX),
        .iY     (iY),
        .iZ     (iZ),
        .oValid (oValid),
        .oReady (oReady),
        .coshOut(coshOut),
        .sinhOut(sinhOut)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    function automatic void chk(input string name, input bit ok, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void chk_tol(input string name, input int act, input int req, input int tol);
        int d;
        d = act - req;
        chk(name, (d <= tol) && (d >= -tol), act, req);
    endfunction

    // Monitor: pops one expectation per result and checks hold/drop behaviour around the handshake
    logic          prev_v = 1'b0, prev_hs = 1'b0, prev_hold = 1'b0, prev_rst = 1'b1;
    logic [DW-1:0] prev_c = '0, prev_s = '0;
    exp_t          e;
    int            lat;

    initial begin
        forever begin
            @(negedge iClk);
            #1;
            if (!prev_rst && prev_hold) begin
                chk("hold_valid", oValid == 1'b1, int'(oValid), 1);
                chk("hold_cosh", coshOut == prev_c, int'($signed(coshOut)), int'($signed(prev_c)));
                chk("hold_sinh", sinhOut == prev_s, int'($signed(sinhOut)), int'($signed(prev_s)));
            end
            if (!prev_rst && prev_hs) begin
                chk("drop_valid", oValid == 1'b0, int'(oValid), 0);
                chk("ready_after_hs", iReady == 1'b1, int'(iReady), 1);
                chk("keep_cosh", coshOut == prev_c, int'($signed(coshOut)), int'($signed(prev_c)));
                chk("keep_sinh", sinhOut == prev_s, int'($signed(sinhOut)), int'($signed(prev_s)));
            end
            if (oValid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1'b0, 1, 0);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc;
                    chk("latency", lat == 19, lat, 19);
                    chk_tol("cosh", int'($signed(coshOut)), e.c, e.tol);
                    chk_tol("sinh", int'($signed(sinhOut)), e.s, e.tol);
                end
            end
            prev_v    = oValid;
            prev_hs   = oValid && oReady;
            prev_hold = oValid && !oReady;
            prev_c    = coshOut;
            prev_s    = sinhOut;
            prev_rst  = iRst;
        end
    end

    // Called at a falling edge; holds the word until it is accepted
    task automatic send(input int v);
        int n = 0;
        iValid = 1'b1;
        iX = DW'(vx[v]);
        iY = '0;
        iZ = DW'(vz[v]);
        while (!iReady && n < 200) begin
            @(negedge iClk);
            n++;
        end
        if (!iReady) chk("accept_timeout", 1'b0, n, 200);
        else sb.push_back('{vc[v], vs[v], vt[v], cyc});
        @(negedge iClk);
        iValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || oValid) && n < 300) begin
            @(negedge iClk);
            n++;
        end
        chk("drain_timeout", n < 300, n, 300);
        @(negedge iClk);
    endtask

    initial begin
        int last_acc;
        int n;
        iRst = 1'b1;
        iValid = 1'b0;
        iX = '0;
        iY = '0;
        iZ = '0;
        oReady = 1'b1;
        repeat (3) @(negedge iClk);
        #1;
        chk("rst_iReady", iReady == 1'b1, int'(iReady), 1);
        chk("rst_oValid", oValid == 1'b0, int'(oValid), 0);
        chk("rst_cosh", coshOut == '0, int'($signed(coshOut)), 0);
        chk("rst_sinh", sinhOut == '0, int'($signed(sinhOut)), 0);
        iRst = 1'b0;
        @(negedge iClk);

        // Unit gain at zero angle, then +/-0.5
        for (int v = 0; v < 3; v++) begin
            send(v);
            drain();
        end

        // Backpressure: result must hold while oReady is low
        oReady = 1'b0;
        send(1);
        repeat (4) @(negedge iClk);
        chk("busy_iReady", iReady == 1'b0, int'(iReady), 0);
        chk("busy_oValid", oValid == 1'b0, int'(oValid), 0);
        n = 0;
        while (!oValid && n < 100) begin
            @(negedge iClk);
            n++;
        end
        chk("wait_valid_timeout", n < 100, n, 100);
        for (int i = 0; i < 10; i++) begin
            @(negedge iClk);
            chk("done_iReady", iReady == 1'b0, int'(iReady), 0);
        end
        oReady = 1'b1;
        drain();

        // Reset in the middle of a computation abandons it silently
        send(2);
        repeat (8) @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        sb.delete();
        @(negedge iClk);
        #1;
        chk("post_rst_iReady", iReady == 1'b1, int'(iReady), 1);
        chk("post_rst_oValid", oValid == 1'b0, int'(oValid), 0);
        repeat (25) @(negedge iClk);
        send(0);
        drain();

        // iValid held high with data rotating every cycle
        last_acc = -1;
        for (int k = 0; k < 65; k++) begin
            iValid = 1'b1;
            iX = DW'(vx[k % 3]);
            iY = '0;
            iZ = DW'(vz[k % 3]);
            if (iReady) begin
                sb.push_back('{vc[k % 3], vs[k % 3], vt[k % 3], cyc});
                if (last_acc >= 0) chk("accept_spacing", (cyc - last_acc) == 20, cyc - last_acc, 20);
                last_acc = cyc;
            end
            @(negedge iClk);
        end
        iValid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s2_hyp_cordic.md
S2_HYP_CORDIC -- requirements
Module: s2_hyp_cordic

Interface
REQ-001 SHALL have parameter INT_WIDTH, default I_INT_WIDTH (hyperCord_pkg), integer bits of every data word.
REQ-002 SHALL have parameter FRA_WIDTH, default I_FRA_WIDTH, fractional bits.
REQ-003 SHALL have parameter SIGN_WIDTH, default I_SIGN_WIDTH, sign bits.
REQ-004 SHALL have parameter DWIDTH, default IDWIDTH (= SIGN_WIDTH+INT_WIDTH+FRA_WIDTH), two's-complement word width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be, clock and reset first:
- iClk, input, 1: rising-edge clock.
- iRst, input, 1: synchronous active-high reset.
- iValid, input, 1: input word set valid.
- iReady, output, 1: block can accept input.
- iX, input, DWIDTH: cosh seed (pre-scaled by 1/Kh from stage1).
- iY, input, DWIDTH: sinh seed.
- iZ, input, DWIDTH: residual angle.
- oValid, output, 1: result valid.
- oReady, input, 1: downstream accepts result.
- coshOut, output, DWIDTH: cosh result.
- sinhOut, output, DWIDTH: sinh result.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, DONE.
REQ-008 In IDLE, iReady SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-009 IDLE->RUN SHALL occur on iValid&&iReady; iX/iY/iZ SHALL be captured into internal x/y/z registers on that edge.
REQ-010 RUN SHALL perform one micro-iteration per cycle over shift index i=1..16, repeating i=4 and i=13, for exactly 18 cycles.
REQ-011 Each micro-iteration SHALL compute d=+1 if z>=0 else -1; x'=x+d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*ATANH[i]; all shifts arithmetic, all updates from pre-update values.
REQ-012 ATANH[i] SHALL be a constant table of atanh(2^-i), i=1..16, rounded to nearest at FRA_WIDTH.
REQ-013 Add/subtract SHALL wrap modulo 2^DWIDTH (no saturation), consistent with fixedAddSub.
REQ-014 After the 18th micro-iteration the FSM SHALL enter DONE with coshOut=x, sinhOut=y registered, and oValid=1.
REQ-015 Latency SHALL be 19 cycles from the accept edge to first oValid=1.
REQ-016 In DONE, oValid, coshOut and sinhOut SHALL hold stable until oValid&&oReady.
REQ-017 On oValid&&oReady the FSM SHALL go to IDLE; oValid SHALL drop the next cycle, and coshOut/sinhOut SHALL keep their last value.
REQ-018 A new input SHALL NOT be accepted in the DONE->IDLE handoff cycle (minimum one-cycle bubble; throughput one result per 20 cycles).
REQ-019 iValid in RUN/DONE SHALL be ignored and SHALL NOT disturb state.
REQ-020 The iteration counter and repeat flag SHALL be internal; the block SHALL NOT apply gain compensation.
REQ-021 For |iZ| > 1.118 (outside the convergence range), the handshake SHALL still complete normally; numerical result unspecified.

Reset
REQ-022 iRst=1 SHALL force IDLE, oValid=0, coshOut=0, sinhOut=0, x/y/z=0, and counter=0 on the next edge.
REQ-023 Reset in RUN or DONE SHALL abandon the operation with no oValid pulse; iReady=1 SHALL return the cycle after iRst deasserts.
REQ-024 Reset SHALL take priority over all handshake events in the same cycle.

Verification (INT_WIDTH=3, FRA_WIDTH=16, values in LSB of 2^-16)
REQ-025 iX=79134 (1/Kh), iY=0, iZ=0, oReady=1 -> oValid at accept+19; coshOut=65536±8, sinhOut=0±8.
REQ-026 iX=79134, iY=0, iZ=32768 (0.5) -> coshOut=73900±16, sinhOut=34151±16.
REQ-027 Same as REQ-026 with iZ=-32768 -> coshOut=73900±16, sinhOut=-34151±16.
REQ-028 oReady held 0 for 10 cycles after oValid -> outputs and oValid stable, iReady=0; on oReady=1, oValid drops the next cycle, and iReady=1 that cycle.
REQ-029 iRst pulsed at RUN cycle 9 -> no oValid ever for that input; next accepted input (REQ-025 values) produces the correct result.
REQ-030 iValid held 1 continuously with changing data -> only the words present on the accept edges are processed; accepts are 20 cycles apart.
